// File: rtl/dmi_arbiter_if.sv
// DMI bundle between two requesters, the arbiter and the debug module.
// Requester-side signals are packed per requester; DM-side signals are scalar.
interface dmi_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [1:0]          req_new_request;
    logic [1:0]          req_rnw;
    logic [2*ADDR_W-1:0] req_address;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_handled;
    logic [3:0]          req_response;
    logic [2*DATA_W-1:0] req_rdata;

    logic                dm_new_request;
    logic                dm_rnw;
    logic [ADDR_W-1:0]   dm_address;
    logic [DATA_W-1:0]   dm_wdata;
    logic                dm_handled;
    logic [1:0]          dm_response;
    logic [DATA_W-1:0]   dm_rdata;

    modport slave (
        input  req_new_request, req_rnw, req_address, req_wdata,
        input  dm_handled, dm_response, dm_rdata,
        output req_handled, req_response, req_rdata,
        output dm_new_request, dm_rnw, dm_address, dm_wdata
    );

    modport master (
        output req_new_request, req_rnw, req_address, req_wdata,
        output dm_handled, dm_response, dm_rdata,
        input  req_handled, req_response, req_rdata,
        input  dm_new_request, dm_rnw, dm_address, dm_wdata
    );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DM DMI port between two masters (0: JTAG DTM,
// 1: secondary host). One outstanding DM transaction, supervised by a timeout.
module dmi_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    dmi_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        pending;
    logic [1:0]        reject;
    logic [1:0]        accept;
    logic [1:0]        overrun;
    logic [1:0]        done_vec;
    logic              grant;
    logic              last_grant;
    logic              pick;
    logic              issue;
    logic              done_ok;
    logic              done_to;
    logic [TW-1:0]     timer;

    logic [1:0]        slot_rnw;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [DATA_W-1:0] slot_wdata [2];

    assign accept   = bus.req_new_request & ~pending;
    assign overrun  = bus.req_new_request &  pending;
    assign done_vec = (done_ok || done_to) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (|pending) state_nxt = S_WAIT;
            S_WAIT: if (bus.dm_handled || timer == T_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A completion and a timeout in the same cycle resolve as a normal completion.
    always_comb begin
        issue   = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        pick    = grant;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    issue = 1'b1;
                    pick  = (&pending) ? ~last_grant : pending[1];
                end
            end
            S_WAIT: begin
                if (bus.dm_handled)      done_ok = 1'b1;
                else if (timer == T_LAST) done_to = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                slot_rnw[i]   <= bus.req_rnw[i];
                slot_addr[i]  <= bus.req_address[i*ADDR_W +: ADDR_W];
                slot_wdata[i] <= bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending            <= 2'b00;
            reject             <= 2'b00;
            grant              <= 1'b0;
            last_grant         <= 1'b1;
            timer              <= '0;
            bus.dm_new_request <= 1'b0;
            bus.dm_rnw         <= 1'b0;
            bus.dm_address     <= '0;
            bus.dm_wdata       <= '0;
            bus.req_handled    <= 2'b00;
            bus.req_response   <= '0;
            bus.req_rdata      <= '0;
        end else begin
            bus.dm_new_request <= issue;
            if (issue) begin
                grant          <= pick;
                bus.dm_rnw     <= slot_rnw[pick];
                bus.dm_address <= slot_addr[pick];
                bus.dm_wdata   <= slot_wdata[pick];
                timer          <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + 1'b1;
            end
            if (done_ok || done_to) last_grant <= grant;

            // A rejected pulse colliding with a real completion is held in reject and replayed next cycle.
            for (int i = 0; i < 2; i++) begin
                pending[i] <= (pending[i] & ~done_vec[i]) | accept[i];
                if (done_vec[i]) begin
                    bus.req_handled[i]            <= 1'b1;
                    bus.req_response[i*2 +: 2]    <= done_ok ? bus.dm_response : 2'd2;
                    bus.req_rdata[i*DATA_W +: DATA_W] <= done_ok ? bus.dm_rdata : '0;
                    reject[i]                     <= reject[i] | overrun[i];
                end else if (reject[i] || overrun[i]) begin
                    bus.req_handled[i]            <= 1'b1;
                    bus.req_response[i*2 +: 2]    <= 2'd3;
                    bus.req_rdata[i*DATA_W +: DATA_W] <= '0;
                    reject[i]                     <= 1'b0;
                end else begin
                    bus.req_handled[i]            <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_dmi_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   h1_seen = 0;
    int   dmreq_seen = 0;

    dmi_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: slots, one owner of the DM port, owed BUSY replies.
    bit          m_valid [2];
    bit          m_rnw   [2];
    bit [AW-1:0] m_addr  [2];
    bit [DW-1:0] m_wdata [2];
    bit          m_owe   [2];
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_last  = 1;
    logic [1:0]    exp_handled = '0;
    logic [3:0]    exp_resp    = '0;
    logic [2*DW-1:0] exp_rdata = '0;
    logic          exp_new = 1'b0, exp_rnw = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    always @(posedge clk) begin : model
        int  comp;
        bit  ok;
        bit  idle;
        bit  over;
        int  w;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin m_valid[i] = 0; m_owe[i] = 0; end
            m_owner = -1; m_age = 0; m_last = 1;
            exp_handled = '0; exp_resp = '0; exp_rdata = '0;
            exp_new = 0; exp_rnw = 0; exp_addr = '0; exp_wdata = '0;
        end else begin
            idle = (m_owner < 0);
            comp = -1; ok = 0;
            if (!idle) begin
                if (bus.dm_handled) begin comp = m_owner; ok = 1; end
                else if (m_age == TO - 1) comp = m_owner;
                else m_age++;
            end
            exp_new = 0;
            if (idle && (m_valid[0] || m_valid[1])) begin
                if (m_valid[0] && m_valid[1]) w = 1 - m_last;
                else w = m_valid[0] ? 0 : 1;
                m_owner = w; m_age = 0; exp_new = 1;
                exp_rnw = m_rnw[w]; exp_addr = m_addr[w]; exp_wdata = m_wdata[w];
            end
            for (int i = 0; i < 2; i++) begin
                over = bus.req_new_request[i] && m_valid[i];
                exp_handled[i] = 0;
                if (comp == i) begin
                    exp_handled[i] = 1;
                    exp_resp[i*2 +: 2] = ok ? bus.dm_response : 2'd2;
                    exp_rdata[i*DW +: DW] = ok ? bus.dm_rdata : '0;
                    m_owe[i] = m_owe[i] | over;
                    m_valid[i] = 0; m_last = i; m_owner = -1;
                end else if (m_owe[i] || over) begin
                    exp_handled[i] = 1;
                    exp_resp[i*2 +: 2] = 2'd3;
                    exp_rdata[i*DW +: DW] = '0;
                    m_owe[i] = 0;
                end
                if (bus.req_new_request[i] === 1'b1 && !over) begin
                    m_valid[i] = 1;
                    m_rnw[i]   = bus.req_rnw[i];
                    m_addr[i]  = bus.req_address[i*AW +: AW];
                    m_wdata[i] = bus.req_wdata[i*DW +: DW];
                end
            end
        end
    end

    function automatic logic [110:0] obs_vec();
        return {bus.req_handled, bus.req_response, bus.req_rdata,
                bus.dm_new_request, bus.dm_rnw, bus.dm_address, bus.dm_wdata};
    endfunction

    function automatic logic [110:0] exp_vec();
        return {exp_handled, exp_resp, exp_rdata, exp_new, exp_rnw, exp_addr, exp_wdata};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bus.req_handled[1] === 1'b1) h1_seen++;
        if (bus.dm_new_request === 1'b1) dmreq_seen++;
    endtask

    task automatic clear_inputs();
        bus.req_new_request = '0; bus.req_rnw = '0; bus.req_address = '0; bus.req_wdata = '0;
        bus.dm_handled = 1'b0; bus.dm_response = '0; bus.dm_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] m, input logic [1:0] rnw,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        bus.req_new_request = m;
        bus.req_rnw         = rnw;
        bus.req_address     = {a1, a0};
        bus.req_wdata       = {w1, w0};
        tick();
        bus.req_new_request = 2'b00;
    endtask

    task automatic dm_reply(input logic [1:0] resp, input logic [DW-1:0] rdata);
        bus.dm_handled  = 1'b1;
        bus.dm_response = resp;
        bus.dm_rdata    = rdata;
        tick();
        bus.dm_handled  = 1'b0;
    endtask

    task automatic wait_dm_req(output bit ok);
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            if (bus.dm_new_request === 1'b1) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_idle: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_single_read();
        do_reset();
        h1_seen = 0;
        drive_req(2'b01, 2'b01, 7'h11, '0, '0, '0);
        checks++;
        if (bus.dm_new_request !== 1'b0) begin
            errors++; $display("FAIL single_early_issue: got %b want 0", bus.dm_new_request);
        end
        tick();
        checks++;
        if ({bus.dm_new_request, bus.dm_rnw, bus.dm_address} !== {1'b1, 1'b1, 7'h11}) begin
            errors++; $display("FAIL single_issue: got %b %b %h want 1 1 11",
                               bus.dm_new_request, bus.dm_rnw, bus.dm_address);
        end
        tick();
        checks++;
        if (bus.dm_new_request !== 1'b0) begin
            errors++; $display("FAIL single_issue_pulse: got %b want 0", bus.dm_new_request);
        end
        tick(); tick();
        dm_reply(2'd0, 32'hDEADBEEF);
        checks++;
        if ({bus.req_handled, bus.req_response[1:0], bus.req_rdata[DW-1:0]} !== {2'b01, 2'd0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL single_handled: got %b %0d %h want 01 0 deadbeef",
                               bus.req_handled, bus.req_response[1:0], bus.req_rdata[DW-1:0]);
        end
        tick();
        checks++;
        if ({bus.req_handled, bus.req_rdata[DW-1:0]} !== {2'b00, 32'hDEADBEEF}) begin
            errors++; $display("FAIL single_hold: got %b %h want 00 deadbeef",
                               bus.req_handled, bus.req_rdata[DW-1:0]);
        end
        checks++;
        if (h1_seen !== 0) begin
            errors++; $display("FAIL single_no_h1: got %0d want 0", h1_seen);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [AW-1:0] want_a [4] = '{7'h10, 7'h20, 7'h30, 7'h40};
        logic [1:0]    want_h [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive_req(2'b11, 2'b00, 7'h10, 7'h20, 32'hA5A5A5A5, 32'h5A5A5A5A);
            if (k == 2) drive_req(2'b11, 2'b00, 7'h30, 7'h40, 32'h0000_0030, 32'h0000_0040);
            wait_dm_req(ok);
            checks++;
            if (!ok || bus.dm_address !== want_a[k] || bus.dm_rnw !== 1'b0) begin
                errors++; $display("FAIL simult_order%0d: got ok=%0d addr %h want addr %h",
                                   k, ok, bus.dm_address, want_a[k]);
            end
            if (k == 0) begin
                checks++;
                if (bus.dm_wdata !== 32'hA5A5A5A5) begin
                    errors++; $display("FAIL simult_wdata0: got %h want a5a5a5a5", bus.dm_wdata);
                end
            end
            if (k == 1) begin
                checks++;
                if (bus.dm_wdata !== 32'h5A5A5A5A) begin
                    errors++; $display("FAIL simult_wdata1: got %h want 5a5a5a5a", bus.dm_wdata);
                end
            end
            dm_reply(2'd0, 32'(k));
            checks++;
            if (bus.req_handled !== want_h[k]) begin
                errors++; $display("FAIL simult_handled%0d: got %b want %b", k, bus.req_handled, want_h[k]);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        dmreq_seen = 0;
        drive_req(2'b10, 2'b10, '0, 7'h22, '0, '0);
        wait_dm_req(ok);
        checks++;
        if (!ok || bus.dm_address !== 7'h22) begin
            errors++; $display("FAIL overrun_issue: got ok=%0d addr %h want 22", ok, bus.dm_address);
        end
        drive_req(2'b10, 2'b00, '0, 7'h33, '0, 32'h1234);
        checks++;
        if ({bus.req_handled, bus.req_response[3:2], bus.req_rdata[2*DW-1:DW], bus.dm_address}
            !== {2'b10, 2'd3, 32'h0, 7'h22}) begin
            errors++; $display("FAIL overrun_busy: got %b %0d %h addr %h want 10 3 0 22",
                               bus.req_handled, bus.req_response[3:2], bus.req_rdata[2*DW-1:DW], bus.dm_address);
        end
        tick();
        checks++;
        if (bus.req_handled !== 2'b00) begin
            errors++; $display("FAIL overrun_single_pulse: got %b want 00", bus.req_handled);
        end
        dm_reply(2'd0, 32'hCAFEF00D);
        checks++;
        if ({bus.req_handled, bus.req_response[3:2], bus.req_rdata[2*DW-1:DW]} !== {2'b10, 2'd0, 32'hCAFEF00D}) begin
            errors++; $display("FAIL overrun_complete: got %b %0d %h want 10 0 cafef00d",
                               bus.req_handled, bus.req_response[3:2], bus.req_rdata[2*DW-1:DW]);
        end
        repeat (5) tick();
        checks++;
        if (dmreq_seen !== 1) begin
            errors++; $display("FAIL overrun_issue_count: got %0d want 1", dmreq_seen);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        drive_req(2'b01, 2'b01, 7'h05, '0, '0, '0);
        wait_dm_req(ok);
        bus.req_new_request = 2'b10;
        bus.req_rnw         = 2'b00;
        bus.req_address     = {7'h44, 7'h00};
        bus.req_wdata       = {32'h1111, 32'h0};
        tick();
        bus.req_new_request = 2'b00;
        n = 1;
        while (bus.req_handled[0] !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (!ok || n !== TO) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO);
        end
        checks++;
        if ({bus.req_response[1:0], bus.req_rdata[DW-1:0]} !== {2'd2, 32'h0}) begin
            errors++; $display("FAIL timeout_resp: got %0d %h want 2 0",
                               bus.req_response[1:0], bus.req_rdata[DW-1:0]);
        end
        dm_reply(2'd0, 32'h99);
        checks++;
        if ({bus.req_handled, bus.dm_new_request, bus.dm_rnw, bus.dm_address, bus.dm_wdata}
            !== {2'b00, 1'b1, 1'b0, 7'h44, 32'h1111}) begin
            errors++; $display("FAIL timeout_next: got %b %b %b %h %h want 00 1 0 44 1111",
                               bus.req_handled, bus.dm_new_request, bus.dm_rnw, bus.dm_address, bus.dm_wdata);
        end
        dm_reply(2'd0, 32'h7);
        checks++;
        if ({bus.req_handled, bus.req_rdata[2*DW-1:DW]} !== {2'b10, 32'h7}) begin
            errors++; $display("FAIL timeout_next_done: got %b %h want 10 7",
                               bus.req_handled, bus.req_rdata[2*DW-1:DW]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        drive_req(2'b01, 2'b01, 7'h55, '0, '0, '0);
        wait_dm_req(ok);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_mid_zero: got %h want 0", obs_vec());
        end
        drive_req(2'b11, 2'b11, 7'h66, 7'h77, '0, '0);
        wait_dm_req(ok);
        checks++;
        if (!ok || bus.dm_address !== 7'h66) begin
            errors++; $display("FAIL reset_mid_prio: got ok=%0d addr %h want 66", ok, bus.dm_address);
        end
        dm_reply(2'd0, 32'h1);
        wait_dm_req(ok);
        dm_reply(2'd0, 32'h2);
    endtask

    task automatic test_failed_resp();
        bit ok;
        do_reset();
        drive_req(2'b10, 2'b10, '0, 7'h08, '0, '0);
        wait_dm_req(ok);
        drive_req(2'b01, 2'b01, 7'h09, '0, '0, '0);
        dm_reply(2'd2, 32'h0BAD);
        checks++;
        if ({bus.req_handled, bus.req_response[3:2], bus.req_rdata[2*DW-1:DW]} !== {2'b10, 2'd2, 32'h0BAD}) begin
            errors++; $display("FAIL failed_resp: got %b %0d %h want 10 2 bad",
                               bus.req_handled, bus.req_response[3:2], bus.req_rdata[2*DW-1:DW]);
        end
        wait_dm_req(ok);
        checks++;
        if (!ok || bus.dm_address !== 7'h09) begin
            errors++; $display("FAIL failed_next_issue: got ok=%0d addr %h want 09", ok, bus.dm_address);
        end
        dm_reply(2'd0, 32'h5);
        checks++;
        if ({bus.req_handled, bus.req_rdata[DW-1:0]} !== {2'b01, 32'h5}) begin
            errors++; $display("FAIL failed_next_done: got %b %h want 01 5",
                               bus.req_handled, bus.req_rdata[DW-1:0]);
        end
    endtask

    task automatic test_random();
        int cnt = 0;
        int r;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (errors < 20) $display("FAIL random cycle %0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            reset = ($urandom_range(0, 399) == 0);
            bus.req_new_request = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            bus.req_rnw     = 2'($urandom);
            bus.req_address = 14'($urandom);
            bus.req_wdata   = {$urandom, $urandom};
            if (exp_new) cnt = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(1, 5);
            if (reset) cnt = 0;
            bus.dm_handled = (cnt == 1) || ($urandom_range(0, 49) == 0);
            if (cnt > 0) cnt--;
            r = $urandom_range(0, 2);
            bus.dm_response = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
            bus.dm_rdata    = $urandom;
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_failed_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
